// File: rtl/lane_arbiter_if.sv
// Lane-side request bus and unit-side valid/ready/done handshake for lane_arbiter.
// master: the arbiter's view; slave: the lane front-ends plus evaluation unit.
interface lane_arbiter_if #(
  parameter int unsigned HW = 5
);
  logic [3:0]      req;
  logic [4*HW-1:0] height_in;
  logic [3:0]      strike_in;
  logic [3:0]      grant;
  logic [3:0]      ack;
  logic            unit_valid;
  logic [HW-1:0]   unit_height;
  logic [1:0]      unit_lane;
  logic            unit_ready;
  logic            unit_done;
  logic            busy;
  logic            timeout_err;

  modport master (
    input  req, height_in, strike_in, unit_ready, unit_done,
    output grant, ack, unit_valid, unit_height, unit_lane, busy, timeout_err
  );

  modport slave (
    output req, height_in, strike_in, unit_ready, unit_done,
    input  grant, ack, unit_valid, unit_height, unit_lane, busy, timeout_err
  );
endinterface

// File: rtl/lane_arbiter.sv
// Round-robin arbiter sharing one height-evaluation unit among 4 lanes.
// Optional STRIKE_PRIORITY_EN: strike lanes win over non-strike lanes.
module lane_arbiter #(
  parameter int unsigned HW      = 5,
  parameter int unsigned TIMEOUT = 15
) (
  input logic           clk,
  input logic           rst,
  lane_arbiter_if.master bus
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e        state_q, state_d;
  logic [1:0]    ptr_q, ptr_d;
  logic [3:0]    grant_q, grant_d;
  logic [3:0]    ack_q, ack_d;
  logic          valid_q, valid_d;
  logic [HW-1:0] height_q, height_d;
  logic [1:0]    lane_q, lane_d;
  logic [7:0]    tcnt_q, tcnt_d;
  logic          terr_q, terr_d;

  logic [3:0]    elig;
  logic [3:0]    cand;
  logic          found;
  logic [1:0]    winner;
  logic [1:0]    scan_idx;

  always_comb begin
    elig = '0;
    for (int i = 0; i < 4; i++) begin
      elig[i] = bus.req[i] && (bus.height_in[i*HW +: HW] != '0);
    end
  end

`ifdef STRIKE_PRIORITY_EN
  logic [3:0] strike_elig;
  assign strike_elig = elig & bus.strike_in;
  assign cand        = (strike_elig != '0) ? strike_elig : elig;
`else
  logic unused_strike;
  assign unused_strike = ^bus.strike_in;
  assign cand          = elig;
`endif

  // First candidate at or after ptr, wrapping mod 4.
  always_comb begin
    found    = 1'b0;
    winner   = ptr_q;
    scan_idx = ptr_q;
    for (int k = 0; k < 4; k++) begin
      scan_idx = ptr_q + 2'(k);
      if (!found && cand[scan_idx]) begin
        found  = 1'b1;
        winner = scan_idx;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    grant_d  = grant_q;
    ack_d    = '0;
    valid_d  = valid_q;
    height_d = height_q;
    lane_d   = lane_q;
    tcnt_d   = tcnt_q;
    terr_d   = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (found) begin
          grant_d  = 4'b0001 << winner;
          lane_d   = winner;
          height_d = bus.height_in[32'(winner)*HW +: HW];
          valid_d  = 1'b1;
          ptr_d    = winner + 2'd1;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (valid_q && bus.unit_ready) begin
          valid_d = 1'b0;
          tcnt_d  = '0;
          state_d = StWait;
        end
      end
      StWait: begin
        tcnt_d = tcnt_q + 8'd1;
        // done takes precedence over a coincident timeout
        if (bus.unit_done) begin
          ack_d   = grant_q;
          grant_d = '0;
          state_d = StIdle;
        end else if (tcnt_q == 8'(TIMEOUT - 1)) begin
          terr_d  = 1'b1;
          grant_d = '0;
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      grant_q  <= '0;
      ack_q    <= '0;
      valid_q  <= 1'b0;
      height_q <= '0;
      lane_q   <= '0;
      tcnt_q   <= '0;
      terr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      grant_q  <= grant_d;
      ack_q    <= ack_d;
      valid_q  <= valid_d;
      height_q <= height_d;
      lane_q   <= lane_d;
      tcnt_q   <= tcnt_d;
      terr_q   <= terr_d;
    end
  end

  assign bus.grant       = grant_q;
  assign bus.ack         = ack_q;
  assign bus.unit_valid  = valid_q;
  assign bus.unit_height = height_q;
  assign bus.unit_lane   = lane_q;
  assign bus.busy        = (state_q != StIdle);
  assign bus.timeout_err = terr_q;

`ifndef SYNTHESIS
  grant_onehot_a: assert property (@(posedge clk) disable iff (rst) $onehot0(grant_q));
  ack_owner_a: assert property (@(posedge clk) disable iff (rst)
    (ack_q != '0) |-> (ack_q == $past(grant_q)));
`endif

endmodule
